// File: rtl/sp_unit_if.sv
// sp_unit_if: request and stack-memory bus between the control unit and sp_unit.
//   master : control unit side; drives op_valid/op/burst_len/load_val/flags_clr
//            and receives the handshake, SP, memory strobe and status outputs.
//   slave  : sp_unit side, with the opposite directions.
interface sp_unit_if #(
    parameter int WIDTH = 16
);
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op;
    logic [2:0]       burst_len;
    logic [WIDTH-1:0] load_val;
    logic             flags_clr;
    logic [WIDTH-1:0] sp_out;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_en;
    logic             mem_we;
    logic             busy;
    logic             burst_done;
    logic             ovf;
    logic             unf;

    modport master (
        output op_valid, op, burst_len, load_val, flags_clr,
        input  op_ready, sp_out, mem_addr, mem_en, mem_we, busy, burst_done, ovf, unf
    );

    modport slave (
        input  op_valid, op, burst_len, load_val, flags_clr,
        output op_ready, sp_out, mem_addr, mem_en, mem_we, busy, burst_done, ovf, unf
    );
endinterface

// File: rtl/sp_unit.sv
// sp_unit: registered, bounds-checked stack pointer with single and burst
// push/pop, direct load, stack memory address/strobe generation and sticky
// overflow/underflow flags.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : sp_unit_if.slave -- request handshake (op_valid/op_ready, op,
//            burst_len, load_val, flags_clr) and outputs (sp_out, mem_addr,
//            mem_en, mem_we, busy, burst_done, ovf, unf)
module sp_unit #(
    parameter int              WIDTH       = 16,
    parameter int              STEP        = 2,
    parameter logic [WIDTH-1:0] STACK_TOP   = 16'h0400,
    parameter logic [WIDTH-1:0] STACK_LIMIT = 16'h0380,
    parameter int              MAX_BURST   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    sp_unit_if.slave    bus
);
    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_LOAD  = 3'd3;
    localparam logic [2:0] OP_BPUSH = 3'd4;
    localparam logic [2:0] OP_BPOP  = 3'd5;

    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH:0]   STEP_X     = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP_W - WIDTH'(1));
    localparam logic [2:0]       MAX_LEN    = 3'(MAX_BURST);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sp, sp_d, addr, addr_d;
    logic             en, en_d, we, we_d, done, done_d;
    logic             ovf, ovf_d, unf, unf_d, dir, dir_d;
    logic [2:0]       rem, rem_d, len_c;
    logic [WIDTH:0]   push_x, pop_x;
    logic             push_ok, pop_ok, accept, go, word_push, word_ok;

    // Bound checks in WIDTH+1 bits: a push below 0 goes negative and a pop
    // past 2^WIDTH-1 carries out, so neither can wrap back into range.
    assign push_x  = {1'b0, sp} - STEP_X;
    assign pop_x   = {1'b0, sp} + STEP_X;
    assign push_ok = $signed(push_x) >= $signed({1'b0, STACK_LIMIT});
    assign pop_ok  = pop_x <= {1'b0, STACK_TOP};

    assign accept = bus.op_valid && (state == ST_IDLE);
    assign len_c  = (bus.burst_len > MAX_LEN) ? MAX_LEN : bus.burst_len;

    always_comb begin
        state_d = state;
        sp_d    = sp;
        addr_d  = addr;
        en_d    = 1'b0;
        we_d    = we;
        done_d  = 1'b0;
        ovf_d   = ovf & ~bus.flags_clr;
        unf_d   = unf & ~bus.flags_clr;
        rem_d   = rem;
        dir_d   = dir;
        go      = 1'b0;

        // Direction of the word that would be issued this cycle.
        word_push = (state == ST_BURST) ? dir : (bus.op == OP_PUSH || bus.op == OP_BPUSH);
        word_ok   = word_push ? push_ok : pop_ok;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.op)
                        OP_PUSH, OP_POP: go = 1'b1;
                        OP_LOAD:         sp_d = bus.load_val & ALIGN_MASK;
                        OP_BPUSH, OP_BPOP: begin
                            if (len_c != 3'd0) begin
                                go    = 1'b1;
                                dir_d = word_push;
                                // A blocked first word ends the burst at once.
                                if (word_ok && len_c >= 3'd2) begin
                                    state_d = ST_BURST;
                                    rem_d   = len_c - 3'd1;
                                end else begin
                                    done_d = 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_BURST: begin
                go    = 1'b1;
                rem_d = rem - 3'd1;
                if (!word_ok || rem == 3'd1) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (go) begin
            if (word_ok) begin
                en_d   = 1'b1;
                we_d   = word_push;
                // Push writes at the new SP; pop reads at the old SP.
                addr_d = word_push ? (sp - STEP_W) : sp;
                sp_d   = word_push ? (sp - STEP_W) : (sp + STEP_W);
            end else if (word_push) begin
                ovf_d = 1'b1;
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sp    <= STACK_TOP;
            addr  <= '0;
            en    <= 1'b0;
            we    <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            rem   <= 3'd0;
            dir   <= 1'b0;
        end else begin
            state <= state_d;
            sp    <= sp_d;
            addr  <= addr_d;
            en    <= en_d;
            we    <= we_d;
            done  <= done_d;
            ovf   <= ovf_d;
            unf   <= unf_d;
            rem   <= rem_d;
            dir   <= dir_d;
        end
    end

    assign bus.op_ready   = (state == ST_IDLE);
    assign bus.busy       = (state == ST_BURST);
    assign bus.sp_out     = sp;
    assign bus.mem_addr   = addr;
    assign bus.mem_en     = en;
    assign bus.mem_we     = we;
    assign bus.burst_done = done;
    assign bus.ovf        = ovf;
    assign bus.unf        = unf;
endmodule

// File: tb/tb_sp_unit.sv
// tb_sp_unit: directed-vector bench for sp_unit with hand-computed expectations.
module tb_sp_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cnt;

    always #5 clk = ~clk;

    sp_unit_if #(.WIDTH(16)) bus ();

    sp_unit #(
        .WIDTH(16), .STEP(2), .STACK_TOP(16'h0400), .STACK_LIMIT(16'h0380), .MAX_BURST(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Present one request before an edge, drop it after; returns #1 past the
    // accepting edge so registered outputs for cycle N+1 are visible.
    task automatic issue(input logic [2:0] op, input logic [2:0] len,
                         input logic [15:0] val, input logic clr);
        @(negedge clk);
        bus.op_valid  = 1'b1;
        bus.op        = op;
        bus.burst_len = len;
        bus.load_val  = val;
        bus.flags_clr = clr;
        @(posedge clk);
        #1;
        bus.op_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.flags_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.op_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.burst_len = 3'd0;
        bus.load_val  = 16'h0;
        bus.flags_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_sp",    bus.sp_out, 16'h0400);
        chk("rst_addr",  bus.mem_addr, 0);
        chk("rst_en",    bus.mem_en, 0);
        chk("rst_we",    bus.mem_we, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_done",  bus.burst_done, 0);
        chk("rst_ovf",   bus.ovf, 0);
        chk("rst_unf",   bus.unf, 0);
        chk("rst_ready", bus.op_ready, 1);

        // PUSH then POP
        issue(3'd1, 3'd0, 16'h0, 1'b0);
        chk("push_en", bus.mem_en, 1);
        chk("push_we", bus.mem_we, 1);
        chk("push_addr", bus.mem_addr, 16'h03FE);
        chk("push_sp", bus.sp_out, 16'h03FE);
        issue(3'd2, 3'd0, 16'h0, 1'b0);
        chk("pop_en", bus.mem_en, 1);
        chk("pop_we", bus.mem_we, 0);
        chk("pop_addr", bus.mem_addr, 16'h03FE);
        chk("pop_sp", bus.sp_out, 16'h0400);
        tick();
        chk("idle_en", bus.mem_en, 0);

        // LOAD aligns down
        issue(3'd3, 3'd0, 16'h0391, 1'b0);
        chk("load_sp", bus.sp_out, 16'h0390);
        chk("load_en", bus.mem_en, 0);

        // BURST_PUSH len=3
        issue(3'd4, 3'd3, 16'h0, 1'b0);
        chk("b3_w1_en", bus.mem_en, 1);
        chk("b3_w1_addr", bus.mem_addr, 16'h038E);
        chk("b3_w1_busy", bus.busy, 1);
        chk("b3_w1_ready", bus.op_ready, 0);
        chk("b3_w1_done", bus.burst_done, 0);
        tick();
        chk("b3_w2_en", bus.mem_en, 1);
        chk("b3_w2_addr", bus.mem_addr, 16'h038C);
        chk("b3_w2_busy", bus.busy, 1);
        chk("b3_w2_done", bus.burst_done, 0);
        tick();
        chk("b3_w3_en", bus.mem_en, 1);
        chk("b3_w3_we", bus.mem_we, 1);
        chk("b3_w3_addr", bus.mem_addr, 16'h038A);
        chk("b3_w3_done", bus.burst_done, 1);
        chk("b3_w3_busy", bus.busy, 0);
        chk("b3_w3_ready", bus.op_ready, 1);
        chk("b3_sp", bus.sp_out, 16'h038A);
        tick();
        chk("b3_after_en", bus.mem_en, 0);
        chk("b3_after_done", bus.burst_done, 0);

        // BURST_PUSH len=4 hits STACK_LIMIT on the third word
        issue(3'd3, 3'd0, 16'h0384, 1'b0);
        issue(3'd4, 3'd4, 16'h0, 1'b0);
        chk("bo_w1_addr", bus.mem_addr, 16'h0382);
        chk("bo_w1_en", bus.mem_en, 1);
        tick();
        chk("bo_w2_addr", bus.mem_addr, 16'h0380);
        chk("bo_w2_en", bus.mem_en, 1);
        chk("bo_w2_ovf", bus.ovf, 0);
        tick();
        chk("bo_w3_en", bus.mem_en, 0);
        chk("bo_w3_ovf", bus.ovf, 1);
        chk("bo_w3_done", bus.burst_done, 1);
        chk("bo_w3_busy", bus.busy, 0);
        chk("bo_sp", bus.sp_out, 16'h0380);
        @(negedge clk);
        bus.flags_clr = 1'b1;
        tick();
        bus.flags_clr = 1'b0;
        chk("ovf_clr", bus.ovf, 0);

        // Illegal POP at top; clear colliding with a new fault
        issue(3'd3, 3'd0, 16'h0400, 1'b0);
        issue(3'd2, 3'd0, 16'h0, 1'b0);
        chk("upop_en", bus.mem_en, 0);
        chk("upop_unf", bus.unf, 1);
        chk("upop_sp", bus.sp_out, 16'h0400);
        issue(3'd2, 3'd0, 16'h0, 1'b1);
        chk("upop_clr_wins", bus.unf, 1);
        @(negedge clk);
        bus.flags_clr = 1'b1;
        tick();
        bus.flags_clr = 1'b0;
        chk("unf_clr", bus.unf, 0);

        // burst_len=1 pulses done with its only word; len=0 is a NOP
        issue(3'd4, 3'd1, 16'h0, 1'b0);
        chk("b1_en", bus.mem_en, 1);
        chk("b1_addr", bus.mem_addr, 16'h03FE);
        chk("b1_done", bus.burst_done, 1);
        chk("b1_busy", bus.busy, 0);
        issue(3'd5, 3'd0, 16'h0, 1'b0);
        chk("b0_en", bus.mem_en, 0);
        chk("b0_done", bus.burst_done, 0);
        chk("b0_sp", bus.sp_out, 16'h03FE);

        // burst_len=7 clamps to 4 words
        issue(3'd3, 3'd0, 16'h0400, 1'b0);
        issue(3'd4, 3'd7, 16'h0, 1'b0);
        cnt = int'(bus.mem_en);
        for (int i = 0; i < 8; i++) begin
            tick();
            cnt += int'(bus.mem_en);
        end
        chk("clamp_words", cnt, 4);
        chk("clamp_sp", bus.sp_out, 16'h03F8);

        // Reset mid BURST_POP after word 2
        issue(3'd4, 3'd0, 16'h0, 1'b0);
        issue(3'd5, 3'd4, 16'h0, 1'b0);
        chk("rb_w1_addr", bus.mem_addr, 16'h03F8);
        chk("rb_w1_we", bus.mem_we, 0);
        chk("rb_w1_sp", bus.sp_out, 16'h03FA);
        tick();
        chk("rb_w2_addr", bus.mem_addr, 16'h03FA);
        chk("rb_w2_sp", bus.sp_out, 16'h03FC);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rb_sp", bus.sp_out, 16'h0400);
        chk("rb_busy", bus.busy, 0);
        chk("rb_en", bus.mem_en, 0);
        chk("rb_done", bus.burst_done, 0);
        tick();
        chk("rb_after_en", bus.mem_en, 0);
        chk("rb_after_done", bus.burst_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sp_unit.md
Name: sp_unit

Overview:
- Parametrised stack-pointer unit: holds SP and performs single and burst push/pop plus direct load.
- Generates the stack memory address and strobe.
- Enforces an alignment-forced SP with configurable step and bounds, and flags overflow/underflow sticky.
- Sits between the control unit and the data-memory port; replaces the combinational SP select with a registered, bounds-checked SP.

Parameters:
- WIDTH, 16, SP and address width.
- STEP, 2, bytes per stack word; must be a power of two ≥1. ALIGN = log2(STEP).
- STACK_TOP, 16'h0400, highest legal SP (empty-stack value, reset value); must be STEP-aligned.
- STACK_LIMIT, 16'h0380, lowest legal SP; must be STEP-aligned and < STACK_TOP.
- MAX_BURST, 4, largest burst_len honoured; must be ≤ 7.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- op_valid  in  1  request valid.
- op_ready  out  1  unit can accept a request this cycle.
- op  in  3  0 NOP, 1 PUSH, 2 POP, 3 LOAD, 4 BURST_PUSH, 5 BURST_POP; 6–7 treated as NOP.
- burst_len  in  3  word count for burst ops; sampled at acceptance.
- load_val  in  WIDTH  new SP for LOAD.
- flags_clr  in  1  clears ovf/unf.
- sp_out  out  WIDTH  current SP (registered).
- mem_addr  out  WIDTH  stack memory address (registered).
- mem_en  out  1  one-cycle strobe per stack word access.
- mem_we  out  1  1 = push (write), 0 = pop (read); qualified by mem_en.
- busy  out  1  burst in progress.
- burst_done  out  1  one-cycle pulse when a burst ends, normally or aborted.
- ovf  out  1  sticky overflow.
- unf  out  1  sticky underflow.

Behaviour:
- Reset (rst_n=0 at edge) values:
  - sp_out=STACK_TOP; mem_addr=0; mem_en=0; mem_we=0; busy=0; burst_done=0; ovf=0; unf=0; state=IDLE.
  - Reset during a burst aborts it without a burst_done pulse.
- Handshake:
  - op_ready = (state==IDLE).
  - A request is accepted on a rising edge with op_valid&op_ready.
  - op, burst_len and load_val are sampled only at acceptance.
- Arithmetic:
  - All SP math is modulo 2^WIDTH.
  - Bound checks are evaluated in WIDTH+1 bits so wrap-around cannot mask a fault.
  - PUSH is legal iff SP-STEP ≥ STACK_LIMIT (signed WIDTH+1 compare).
  - POP is legal iff SP+STEP ≤ STACK_TOP.
- PUSH accepted at edge N:
  - After N, sp_out = SP-STEP.
  - In cycle N+1: mem_en=1, mem_we=1, mem_addr = new SP.
- POP accepted at edge N:
  - In cycle N+1: mem_en=1, mem_we=0, mem_addr = old SP.
  - After N, sp_out = SP+STEP.
- LOAD: sp_out = load_val with low ALIGN bits cleared. No mem_en, no bound check, flags unchanged.
- Illegal push/pop:
  - SP unchanged, mem_en stays 0.
  - ovf (push) or unf (pop) is set in the following cycle.
- State machine: IDLE, BURST.
  - IDLE: burst op with burst_len≥1 performs word 1 exactly as PUSH/POP.
    - If burst_len ≥ 2 (clamped to MAX_BURST), go to BURST with remaining = len-1.
    - If len==1, stay in IDLE and pulse burst_done in cycle N+1.
    - burst_len=0 is accepted as a NOP with no burst_done.
  - BURST: busy=1, op_ready=0.
    - One word per cycle, back-to-back mem_en, same direction; decrement remaining.
    - When the last word is issued, return to IDLE; burst_done pulses in the same cycle as the last mem_en.
    - A bound violation on any word sets the flag, issues no access, pulses burst_done and returns to IDLE. Words already issued are not undone.
- Flags:
  - flags_clr clears ovf and unf at the next edge.
  - A new fault detected in the same cycle as flags_clr wins, so the flag stays 1.
  - Flags never block further ops.
- NOP, or no acceptance: all registers hold; mem_en=0.

Test Plan:
- Reset → sp_out=0x0400, all strobes and flags 0, op_ready=1.
- PUSH, then POP → cycle 1: mem_en=1, we=1, addr=0x03FE, sp=0x03FE; cycle 2: mem_en=1, we=0, addr=0x03FE, sp=0x0400.
- LOAD 0x0391 → sp=0x0390. BURST_PUSH len=3 → three consecutive writes at 0x038E, 0x038C, 0x038A; busy high for 2 cycles; burst_done with the third strobe; op_ready low until done.
- LOAD 0x0384, BURST_PUSH len=4 → writes at 0x0382 and 0x0380, third word blocked; ovf=1, burst_done pulse, sp=0x0380.
- POP at sp=0x0400 → no mem_en, unf=1, sp unchanged. Asserting flags_clr in the same cycle as a second illegal POP leaves unf=1; flags_clr alone then clears it.
- Reset asserted mid-burst (BURST_POP len=4 from 0x03F8, after word 2) → next cycle sp=0x0400, busy=0, no further mem_en, no burst_done.
